// File: rtl/full_adder.sv
// Registered ripple-carry full adder.
// Generate loop of 1-bit cells feeding a single output register stage.

module full_adder_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;

  assign p   = a_i ^ b_i;
  assign s_o = p ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & p);

endmodule

module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;
  logic             vld_d, vld_q;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .c_i (c[i]),
      .s_o (s[i]),
      .c_o (c[i+1])
    );
  end

  // Capture a new result only when the input is qualified; otherwise hold.
  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      sum_d  = s;
      cout_d = c[WIDTH];
      ovf_d  = c[WIDTH] ^ c[WIDTH-1];
      vld_d  = 1'b1;
    end
  end

  // Output register stage; async reset clears results and the valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      vld_q  <= vld_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a WIDTH=1 and a WIDTH=8 instance
// driven by directed vectors plus a random valid/invalid run.

module tb_full_adder;

  logic       clk;
  logic       rst_n;

  logic       v1, a1, b1, c1;
  logic       s1, co1, ov1, ov1v;

  logic       v8, c8;
  logic [7:0] a8, b8;
  logic [7:0] s8;
  logic       co8, ov8, ov8v;

  int total;
  int passed;

  full_adder #(.WIDTH(1)) u1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .a         (a1),
    .b         (b1),
    .cin       (c1),
    .sum       (s1),
    .cout      (co1),
    .ovf       (ov1),
    .out_valid (ov1v)
  );

  full_adder #(.WIDTH(8)) u8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v8),
    .a         (a8),
    .b         (b8),
    .cin       (c8),
    .sum       (s8),
    .cout      (co8),
    .ovf       (ov8),
    .out_valid (ov8v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    v8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({s1, co1, ov1, ov1v} !== 4'b0000)
        $display("FAIL reset_w1 cyc%0d got=%b exp=0000", k,
                 {s1, co1, ov1, ov1v});
      else passed++;
      total++;
      if ({s8, co8, ov8, ov8v} !== 11'd0)
        $display("FAIL reset_w8 cyc%0d got=%h exp=0", k,
                 {s8, co8, ov8, ov8v});
      else passed++;
    end
    v1 = 0; v8 = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    v1 = 1; a1 = 1; b1 = 1; c1 = 1;
    v8 = 1; a8 = 8'h0F; b8 = 8'h01; c8 = 0;
    tick();
    v1 = 0; v8 = 0;
    total++;
    if ({s1, co1, ov1v} !== 3'b111 || s8 !== 8'h10)
      $display("FAIL pre_async got=%b/%h exp=111/10",
               {s1, co1, ov1v}, s8);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({s1, co1, ov1, ov1v} !== 4'b0000 ||
        {s8, co8, ov8, ov8v} !== 11'd0)
      $display("FAIL async_clear got=%b/%h exp=0/0",
               {s1, co1, ov1, ov1v}, {s8, co8, ov8, ov8v});
    else passed++;
    tick();
    rst_n = 1'b1;
    v1 = 1; a1 = 1; b1 = 0; c1 = 0;
    tick();
    v1 = 0;
    total++;
    if ({s1, co1, ov1v} !== 3'b101)
      $display("FAIL first_after_rel got=%b exp=101", {s1, co1, ov1v});
    else passed++;
  endtask

  task automatic test_exhaustive_w1();
    logic [2:0] abc;
    logic [1:0] r;
    int         sv;
    logic       eo;
    for (int k = 0; k < 8; k++) begin
      abc = 3'(k);
      v1 = 1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
      tick();
      r  = 2'(int'(abc[2]) + int'(abc[1]) + int'(abc[0]));
      sv = -int'(abc[2]) - int'(abc[1]) + int'(abc[0]);
      eo = (sv > 0) || (sv < -1);
      total++;
      if ({co1, s1, ov1, ov1v} !== {r, eo, 1'b1})
        $display("FAIL exh_w1 abc=%b got=%b exp=%b", abc,
                 {co1, s1, ov1, ov1v}, {r, eo, 1'b1});
      else passed++;
    end
    v1 = 0;
  endtask

  task automatic test_hold();
    v1 = 1; a1 = 1; b1 = 0; c1 = 0;
    tick();
    total++;
    if ({s1, co1, ov1v} !== 3'b101)
      $display("FAIL hold_load got=%b exp=101", {s1, co1, ov1v});
    else passed++;
    v1 = 0; a1 = 1; b1 = 1; c1 = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if ({s1, co1, ov1v} !== 3'b100)
        $display("FAIL hold cyc%0d got=%b exp=100", k, {s1, co1, ov1v});
      else passed++;
    end
  endtask

  task automatic test_w8_vec(input logic [7:0] a, input logic [7:0] b,
                             input logic ci, input logic [7:0] es,
                             input logic ec, input logic eo);
    v8 = 1; a8 = a; b8 = b; c8 = ci;
    tick();
    v8 = 0;
    total++;
    if ({co8, s8, ov8, ov8v} !== {ec, es, eo, 1'b1})
      $display("FAIL w8 %h+%h+%b got=%b_%h_%b_%b exp=%b_%h_%b_1",
               a, b, ci, co8, s8, ov8, ov8v, ec, es, eo);
    else passed++;
  endtask

  task automatic test_w8_directed();
    test_w8_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    test_w8_vec(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
    test_w8_vec(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    test_w8_vec(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    test_w8_vec(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    logic [8:0] exp_r;
    logic       exp_o;
    logic [7:0] ra, rb;
    logic       rc, rv;
    int         sv;
    exp_r = {co8, s8};
    exp_o = ov8;
    for (int k = 0; k < 1000; k++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      v8 = rv; a8 = ra; b8 = rb; c8 = rc;
      tick();
      if (rv) begin
        exp_r = 9'(int'(ra) + int'(rb) + int'(rc));
        sv    = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
        exp_o = (sv > 127) || (sv < -128);
      end
      total++;
      if ({co8, s8, ov8, ov8v} !== {exp_r, exp_o, rv})
        $display("FAIL rand%0d got=%h_%b_%b exp=%h_%b_%b", k,
                 {co8, s8}, ov8, ov8v, exp_r, exp_o, rv);
      else passed++;
    end
    v8 = 0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b1;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    #2;
    test_reset();
    test_exhaustive_w1();
    test_hold();
    test_w8_directed();
    test_async_reset();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
